// File: rtl/arbitro_memoria_if.sv
`default_nettype none
// ============================================================================
//  Interface : arbitro_memoria_if
//  Purpose   : Bundles the IF-stage, MEM-stage and RAM-side signals of the
//              memory arbiter. "slave" is the arbiter's view, "master" is the
//              view of the pipeline stages plus the RAM around it.
//  Revision  : 1.0 - initial release
// ============================================================================
interface arbitro_memoria_if;
  // instruction fetch port
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  // data (load/store) port
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  // pipeline freeze controls
  logic        stall_if;
  logic        stall_mem;
  // single-port RAM side
  logic        ram_en;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  modport slave (
    input  if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, ram_rdata,
    output if_rdata, if_ack, mem_rdata, mem_ack, stall_if, stall_mem,
           ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, ram_rdata,
    input  if_rdata, if_ack, mem_rdata, mem_ack, stall_if, stall_mem,
           ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface
`default_nettype wire

// File: rtl/arbitro_memoria.sv
`default_nettype none
// ============================================================================
//  Module    : arbitro_memoria
//  Purpose   : Shares one single-port RAM between instruction fetch (IF) and
//              data access (MEM). Each access runs IDLE -> BUSY -> DONE, with
//              BUSY stretched over the RAM read latency. MEM has priority
//              unless IF has waited through MAX_ESPERA data grants.
//  Revision  : 1.0 - initial release
// ============================================================================
module arbitro_memoria #(
  parameter int LAT_RAM    = 2,  // read latency of the RAM, 1..15
  parameter int MAX_ESPERA = 4   // data grants tolerated while IF waits, 1..15
) (
  input  logic             clk,
  input  logic             reset,
  arbitro_memoria_if.slave bus
);

  localparam logic [3:0] LAT_LAST     = 4'(LAT_RAM);
  localparam logic [3:0] ESPERA_LIMIT = 4'(MAX_ESPERA);
  localparam logic [3:0] ESPERA_SAT   = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_d;
  logic [3:0]  lat_cnt, lat_cnt_d;
  logic [3:0]  espera, espera_d;
  logic        gnt_if, gnt_if_d;      // owner of the access in flight
  logic        gnt_we, gnt_we_d;      // access in flight is a store
  logic        ram_en_q, ram_en_d;
  logic        ram_we_q, ram_we_d;
  logic [31:0] ram_addr_q, ram_addr_d;
  logic [31:0] ram_wdata_q, ram_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        if_ack_q, if_ack_d;
  logic        mem_ack_q, mem_ack_d;

  logic mem_req;
  logic pick_if;

  // A simultaneous rd+wr counts as a single request and is treated as a store.
  assign mem_req = bus.mem_rd | bus.mem_wr;
  // IF wins when it is alone or when it has been passed over too often.
  assign pick_if = bus.if_req & (~mem_req | (espera >= ESPERA_LIMIT));

  // Registers: state, counters, latched access and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      lat_cnt     <= 4'd0;
      espera      <= 4'd0;
      gnt_if      <= 1'b0;
      gnt_we      <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= 32'd0;
      ram_wdata_q <= 32'd0;
      if_rdata_q  <= 32'd0;
      mem_rdata_q <= 32'd0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
    end else begin
      state       <= state_d;
      lat_cnt     <= lat_cnt_d;
      espera      <= espera_d;
      gnt_if      <= gnt_if_d;
      gnt_we      <= gnt_we_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
    end
  end

  // Next-state logic plus next values of the registered outputs.
  always_comb begin
    state_d     = state;
    lat_cnt_d   = lat_cnt;
    espera_d    = espera;
    gnt_if_d    = gnt_if;
    gnt_we_d    = gnt_we;
    ram_en_d    = 1'b0;            // strobes are single-cycle by default
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;

    case (state)
      IDLE: begin
        if (!bus.if_req) begin
          espera_d = 4'd0;
        end
        if (pick_if) begin
          gnt_if_d   = 1'b1;
          gnt_we_d   = 1'b0;
          ram_addr_d = bus.if_addr;
          ram_en_d   = 1'b1;
          lat_cnt_d  = 4'd0;
          espera_d   = 4'd0;
          state_d    = BUSY;
        end else if (mem_req) begin
          gnt_if_d    = 1'b0;
          gnt_we_d    = bus.mem_wr;
          ram_addr_d  = bus.mem_addr;
          ram_wdata_d = bus.mem_wdata;
          ram_en_d    = 1'b1;
          ram_we_d    = bus.mem_wr;
          lat_cnt_d   = 4'd0;
          // IF was left waiting by this grant: count it, saturating.
          if (bus.if_req && (espera != ESPERA_SAT)) begin
            espera_d = espera + 4'd1;
          end
          state_d = BUSY;
        end
      end

      BUSY: begin
        if (gnt_we) begin
          // Stores complete in the strobe cycle itself.
          mem_ack_d = 1'b1;
          state_d   = DONE;
        end else if (lat_cnt == LAT_LAST) begin
          // RAM data is valid now; hand it to the owning port only.
          if (gnt_if) begin
            if_rdata_d = bus.ram_rdata;
            if_ack_d   = 1'b1;
          end else begin
            mem_rdata_d = bus.ram_rdata;
            mem_ack_d   = 1'b1;
          end
          state_d = DONE;
        end else begin
          lat_cnt_d = lat_cnt + 4'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.ram_en    = ram_en_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.mem_ack   = mem_ack_q;

  // Stalls follow the requests combinationally so the pipeline freezes in
  // the very cycle a request is raised.
  assign bus.stall_if  = bus.if_req & ~if_ack_q;
  assign bus.stall_mem = mem_req & ~mem_ack_q;

endmodule
`default_nettype wire

// File: tb/tb_arbitro_memoria.sv
`default_nettype none
// ============================================================================
//  Module    : tb_arbitro_memoria
//  Purpose   : Self-checking bench for arbitro_memoria: RAM model with
//              LAT_RAM read latency, a transaction-level reference model
//              compared every cycle, and directed scenarios with literal
//              expectations.
//  Revision  : 1.0 - initial release
// ============================================================================
module tb_arbitro_memoria;

  localparam int LAT_RAM    = 2;
  localparam int MAX_ESPERA = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  arbitro_memoria_if bus ();

  arbitro_memoria #(.LAT_RAM(LAT_RAM), .MAX_ESPERA(MAX_ESPERA)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, need %h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, need %b", name, act, exp);
  endtask

  // ---------------- RAM model: data valid LAT_RAM cycles after ram_en ------
  logic [31:0] ram_mem [0:255];
  logic [31:0] stage   [0:LAT_RAM-1];
  logic [31:0] shadow  [0:255];        // reference model's view of memory

  always @(posedge clk) begin
    if (bus.ram_en && bus.ram_we) ram_mem[bus.ram_addr[9:2]] <= bus.ram_wdata;
    stage[0] <= (bus.ram_en && !bus.ram_we) ? ram_mem[bus.ram_addr[9:2]] : 32'hBAD0BAD0;
    for (int i = 1; i < LAT_RAM; i++) stage[i] <= stage[i-1];
  end
  assign bus.ram_rdata = stage[LAT_RAM-1];

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = 32'h0;
      shadow[i]  = 32'h0;
    end
    for (int i = 0; i < LAT_RAM; i++) stage[i] = 32'hBAD0BAD0;
    ram_mem[4]  = 32'h20000001; shadow[4]  = 32'h20000001;  // 0x10
    ram_mem[5]  = 32'h11111111; shadow[5]  = 32'h11111111;  // 0x14
    ram_mem[6]  = 32'h33333333; shadow[6]  = 32'h33333333;  // 0x18
    ram_mem[7]  = 32'h55555555; shadow[7]  = 32'h55555555;  // 0x1C
    ram_mem[17] = 32'h22222222; shadow[17] = 32'h22222222;  // 0x44
    ram_mem[18] = 32'h44444444; shadow[18] = 32'h44444444;  // 0x48
  end

  // ---------------- Transaction-level reference model -----------------------
  // A grant decided in cycle g produces: strobe in g+1, ack in g+2 (store) or
  // g+LAT_RAM+2 (load), next sampling from ack+1.
  int          cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit          m_active = 1'b0;
  bit          m_if, m_we;
  logic [31:0] m_addr, m_wdata;
  int          m_g, m_done, m_free = 0, m_espera = 0;
  logic [31:0] m_if_rdata = 32'h0, m_mem_rdata = 32'h0;

  always @(negedge clk) begin : model_cmp
    logic e_en, e_we, e_if_ack, e_mem_ack;
    bit   mreq, take_if, take_mem;
    int   k;
    if (reset) begin
      chk1("rst_ram_en", bus.ram_en, 1'b0);
      chk1("rst_ram_we", bus.ram_we, 1'b0);
      chk1("rst_if_ack", bus.if_ack, 1'b0);
      chk1("rst_mem_ack", bus.mem_ack, 1'b0);
      chk32("rst_if_rdata", bus.if_rdata, 32'h0);
      chk32("rst_mem_rdata", bus.mem_rdata, 32'h0);
      m_active = 1'b0; m_free = 0; m_espera = 0;
      m_if_rdata = 32'h0; m_mem_rdata = 32'h0;
    end else begin
      e_en = 1'b0; e_we = 1'b0; e_if_ack = 1'b0; e_mem_ack = 1'b0;
      if (m_active) begin
        k    = cyc - m_g;
        e_en = (k == 1);
        e_we = (k == 1) && m_we;
        if (k >= 1 && cyc < m_done) begin
          chk32("m_ram_addr", bus.ram_addr, m_addr);
          if (m_we) chk32("m_ram_wdata", bus.ram_wdata, m_wdata);
        end
        if (cyc == m_done) begin
          if (m_if) e_if_ack = 1'b1; else e_mem_ack = 1'b1;
          if (!m_we) begin
            if (m_if) m_if_rdata = shadow[m_addr[9:2]];
            else      m_mem_rdata = shadow[m_addr[9:2]];
          end
        end
      end
      chk1("m_ram_en", bus.ram_en, e_en);
      chk1("m_ram_we", bus.ram_we, e_we);
      chk1("m_if_ack", bus.if_ack, e_if_ack);
      chk1("m_mem_ack", bus.mem_ack, e_mem_ack);
      chk32("m_if_rdata", bus.if_rdata, m_if_rdata);
      chk32("m_mem_rdata", bus.mem_rdata, m_mem_rdata);
      chk1("m_stall_if", bus.stall_if, bus.if_req && !e_if_ack);
      chk1("m_stall_mem", bus.stall_mem, (bus.mem_rd || bus.mem_wr) && !e_mem_ack);
      if (m_active && cyc == m_done) begin
        m_active = 1'b0;
        m_free   = cyc + 1;
      end
      if (!m_active && cyc >= m_free) begin
        mreq     = bus.mem_rd || bus.mem_wr;
        take_if  = bus.if_req && (!mreq || m_espera >= MAX_ESPERA);
        take_mem = mreq && !take_if;
        if (!bus.if_req) m_espera = 0;
        if (take_if) begin
          m_espera = 0;
          m_active = 1'b1; m_if = 1'b1; m_we = 1'b0;
          m_addr   = bus.if_addr; m_g = cyc; m_done = cyc + LAT_RAM + 2;
        end else if (take_mem) begin
          if (bus.if_req && m_espera < 15) m_espera = m_espera + 1;
          m_active = 1'b1; m_if = 1'b0; m_we = bus.mem_wr;
          m_addr   = bus.mem_addr; m_wdata = bus.mem_wdata; m_g = cyc;
          m_done   = m_we ? cyc + 2 : cyc + LAT_RAM + 2;
          if (m_we) shadow[m_addr[9:2]] = m_wdata;
        end
      end
    end
  end

  // ---------------- Directed scenarios -------------------------------------
  int cur;

  task automatic begin_test();
    repeat (2) @(posedge clk);
    #1;
    cur = 0;
  endtask

  // sample point of relative cycle n (just after the falling edge)
  task automatic at(input int n);
    repeat (n - cur) @(posedge clk);
    @(negedge clk);
    #1;
    cur = n;
  endtask

  // drive point at the start of relative cycle n (n > current cycle)
  task automatic at_start(input int n);
    repeat (n - cur) @(posedge clk);
    #1;
    cur = n;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, need completion");
    $fatal(1);
  end

  initial begin : stim
    int cnt;
    bus.if_req = 0; bus.if_addr = 0;
    bus.mem_rd = 0; bus.mem_wr = 0; bus.mem_addr = 0; bus.mem_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk32("reset_ram_addr", bus.ram_addr, 32'h0);
    chk32("reset_ram_wdata", bus.ram_wdata, 32'h0);
    reset = 0;

    // 1: IF read only
    begin_test();
    bus.if_req = 1; bus.if_addr = 32'h10;
    at(0); chk1("t1_stall_c0", bus.stall_if, 1'b1);
    at(1); chk1("t1_ram_en", bus.ram_en, 1'b1);
           chk32("t1_ram_addr", bus.ram_addr, 32'h10);
           chk1("t1_ram_we", bus.ram_we, 1'b0);
    at(3); chk1("t1_stall_c3", bus.stall_if, 1'b1);
           chk1("t1_no_early_ack", bus.if_ack, 1'b0);
    at(4); chk1("t1_if_ack", bus.if_ack, 1'b1);
           chk32("t1_if_rdata", bus.if_rdata, 32'h20000001);
           chk1("t1_stall_c4", bus.stall_if, 1'b0);
    at_start(5); bus.if_req = 0;

    // 2: store, then read back
    begin_test();
    bus.mem_wr = 1; bus.mem_addr = 32'h40; bus.mem_wdata = 32'hDEADBEEF;
    at(1); chk1("t2_ram_en", bus.ram_en, 1'b1);
           chk1("t2_ram_we", bus.ram_we, 1'b1);
           chk32("t2_ram_wdata", bus.ram_wdata, 32'hDEADBEEF);
           chk1("t2_stall_mem", bus.stall_mem, 1'b1);
    at(2); chk1("t2_mem_ack", bus.mem_ack, 1'b1);
    at_start(3); bus.mem_wr = 0; bus.mem_rd = 1;
    at(7); chk1("t2_rb_ack", bus.mem_ack, 1'b1);
           chk32("t2_rb_data", bus.mem_rdata, 32'hDEADBEEF);
    at_start(8); bus.mem_rd = 0;

    // 3: simultaneous IF and MEM reads
    begin_test();
    bus.if_req = 1; bus.if_addr = 32'h14;
    bus.mem_rd = 1; bus.mem_addr = 32'h44;
    at(1); chk32("t3_first_addr", bus.ram_addr, 32'h44);
    at(4); chk1("t3_mem_ack", bus.mem_ack, 1'b1);
           chk32("t3_mem_rdata", bus.mem_rdata, 32'h22222222);
           chk1("t3_if_wait", bus.stall_if, 1'b1);
    at_start(5); bus.mem_rd = 0;
    at(6); chk1("t3_if_en", bus.ram_en, 1'b1);
           chk32("t3_if_addr", bus.ram_addr, 32'h14);
    at(8); chk1("t3_stall_c8", bus.stall_if, 1'b1);
    at(9); chk1("t3_if_ack", bus.if_ack, 1'b1);
           chk32("t3_if_rdata", bus.if_rdata, 32'h11111111);
    at_start(10); bus.if_req = 0;

    // 4: starvation of IF by back-to-back loads
    begin_test();
    bus.if_req = 1; bus.if_addr = 32'h18;
    bus.mem_rd = 1; bus.mem_addr = 32'h48;
    cnt = 0;
    for (int c = 1; c <= 24; c++) begin
      at(c);
      if (bus.mem_ack) cnt++;
      if (c == 19) chk32("t4_espera_full", {28'd0, dut.espera}, 32'd4);
      if (c == 21) begin
        chk32("t4_if_addr", bus.ram_addr, 32'h18);
        chk32("t4_espera_clr", {28'd0, dut.espera}, 32'd0);
      end
    end
    chk32("t4_mem_acks", cnt, 32'd4);
    chk1("t4_if_ack", bus.if_ack, 1'b1);
    chk32("t4_if_rdata", bus.if_rdata, 32'h33333333);
    at_start(25); bus.if_req = 0;
    at(29); chk1("t4_mem_after", bus.mem_ack, 1'b1);
    at_start(30); bus.mem_rd = 0;

    // 6: rd+wr together is a store; mem_rdata untouched
    begin_test();
    bus.mem_rd = 1; bus.mem_wr = 1; bus.mem_addr = 32'h80; bus.mem_wdata = 32'hCAFEF00D;
    at(1); chk1("t6_ram_we", bus.ram_we, 1'b1);
           chk32("t6_ram_addr", bus.ram_addr, 32'h80);
    at(2); chk1("t6_mem_ack", bus.mem_ack, 1'b1);
           chk32("t6_mem_rdata", bus.mem_rdata, 32'h44444444);
    at_start(3); bus.mem_rd = 0; bus.mem_wr = 0;
    bus.if_req = 1; bus.if_addr = 32'h80;
    at(7); chk32("t6_readback", bus.if_rdata, 32'hCAFEF00D);
    at_start(8); bus.if_req = 0;

    // 5: reset in the 2nd BUSY cycle of an IF read
    begin_test();
    bus.if_req = 1; bus.if_addr = 32'h1C;
    at(2); reset = 1; bus.if_req = 0;
    #1; chk1("t5_en_drop", bus.ram_en, 1'b0);
        chk1("t5_we_drop", bus.ram_we, 1'b0);
    at_start(4); reset = 0;
    cnt = 0;
    for (int c = 4; c <= 8; c++) begin
      at(c);
      if (bus.if_ack) cnt++;
    end
    chk32("t5_no_ack", cnt, 32'd0);
    begin_test();
    bus.if_req = 1; bus.if_addr = 32'h1C;
    at(3); chk1("t5_not_yet", bus.if_ack, 1'b0);
    at(4); chk1("t5_ack", bus.if_ack, 1'b1);
           chk32("t5_rdata", bus.if_rdata, 32'h55555555);
    at_start(5); bus.if_req = 0;

    // reset while a store strobe is on the RAM: strobes must fall at once
    begin_test();
    bus.mem_wr = 1; bus.mem_addr = 32'h90; bus.mem_wdata = 32'h12345678;
    at(1); chk1("tr_en_before", bus.ram_en, 1'b1);
    reset = 1;
    #1; chk1("tr_en_async", bus.ram_en, 1'b0);
        chk1("tr_we_async", bus.ram_we, 1'b0);
    bus.mem_wr = 0;
    at_start(3); reset = 0;
    at(4); chk1("tr_no_ack", bus.mem_ack, 1'b0);

    begin_test();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
